// File: rtl/program_loader.sv
// program_loader: boot-time sequencer in front of the core's instruction BRAM.
// Streams a program into instruction memory while the core is held in reset,
// then releases the core, hands the BRAM address to the core's fetch stage and
// counts run cycles until the core reports done or the run times out.
module program_loader #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int TIMEOUT    = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   len,
    input  logic                  s_valid,
    input  logic [WIDTH-1:0]      s_data,
    output logic                  s_ready,
    input  logic [WIDTH-1:0]      core_im_addr,
    output logic [WIDTH-1:0]      im_addr,
    output logic                  im_we,
    output logic [WIDTH-1:0]      im_wdata,
    output logic                  core_rst,
    input  logic                  core_done,
    output logic                  busy,
    output logic                  finished,
    output logic                  error,
    output logic [WIDTH-1:0]      cycle_count
);

    localparam int                  MAX_WORDS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] MAX_LEN   = (ADDR_WIDTH + 1)'(MAX_WORDS);
    localparam logic [ADDR_WIDTH:0] IDX_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] IDX_ZERO  = {(ADDR_WIDTH + 1){1'b0}};
    localparam logic [WIDTH-1:0]    CNT_ONE   = {{(WIDTH - 1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]    CNT_ZERO  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]    CNT_LIMIT = WIDTH'(TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_RUN   = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic [ADDR_WIDTH:0] len_r;
    logic [ADDR_WIDTH:0] idx_r;
    logic [ADDR_WIDTH:0] idx_next_s;
    logic [WIDTH-1:0]    addr_r;
    logic [WIDTH-1:0]    wdata_r;
    logic                we_r;
    logic [WIDTH-1:0]    cycle_r;
    logic [WIDTH-1:0]    cycle_next_s;
    logic                error_r;
    logic                hs_s;
    logic                last_s;
    logic                start_ok_s;
    logic                len_ok_s;
    logic                timeout_s;

    // Handshake, length qualification and counter helpers.
    always_comb begin
        hs_s         = s_valid && (state_r == ST_LOAD);
        idx_next_s   = idx_r + IDX_ONE;
        last_s       = (idx_next_s == len_r);
        start_ok_s   = start && ((state_r == ST_IDLE) || (state_r == ST_HALT));
        len_ok_s     = (len != IDX_ZERO) && (len <= MAX_LEN);
        cycle_next_s = cycle_r + CNT_ONE;
        timeout_s    = (cycle_next_s == CNT_LIMIT);
    end

    // Next-state decode for the boot sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE, ST_HALT: begin
                if (start_ok_s) begin
                    if (len_ok_s) begin
                        state_next_s = ST_LOAD;
                    end else begin
                        state_next_s = ST_HALT;
                    end
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_LOAD: begin
                if (hs_s && last_s) begin
                    state_next_s = ST_FLUSH;
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_FLUSH: begin
                state_next_s = ST_RUN;
            end
            ST_RUN: begin
                if (core_done || timeout_s) begin
                    state_next_s = ST_HALT;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Load write register, word index, run counter and sticky error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_r   <= IDX_ZERO;
            idx_r   <= IDX_ZERO;
            addr_r  <= CNT_ZERO;
            wdata_r <= CNT_ZERO;
            we_r    <= 1'b0;
            cycle_r <= CNT_ZERO;
            error_r <= 1'b0;
        end else begin
            // A write is presented exactly one cycle after each accepted word.
            we_r <= hs_s;
            if (hs_s) begin
                addr_r  <= WIDTH'(idx_r) << 2'd2;
                wdata_r <= s_data;
                idx_r   <= idx_next_s;
            end
            if (start_ok_s) begin
                if (len_ok_s) begin
                    len_r   <= len;
                    idx_r   <= IDX_ZERO;
                    cycle_r <= CNT_ZERO;
                    error_r <= 1'b0;
                end else begin
                    error_r <= 1'b1;
                end
            end
            if (state_r == ST_RUN) begin
                cycle_r <= cycle_next_s;
                if (timeout_s && !core_done) begin
                    error_r <= 1'b1;
                end
            end
        end
    end

    // Output decode from registered state; the fetch address is the only
    // combinational path, handed straight to the BRAM while the core runs.
    always_comb begin
        s_ready     = (state_r == ST_LOAD);
        busy        = (state_r == ST_LOAD) || (state_r == ST_FLUSH) || (state_r == ST_RUN);
        finished    = (state_r == ST_HALT);
        core_rst    = (state_r != ST_RUN);
        im_we       = we_r;
        im_wdata    = wdata_r;
        error       = error_r;
        cycle_count = cycle_r;
        if (state_r == ST_RUN) begin
            im_addr = core_im_addr;
        end else begin
            im_addr = addr_r;
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: scoreboard bench for program_loader with random
// program images, random stream gaps and random core completion times.
module tb_program_loader;

    localparam int W       = 32;
    localparam int AW      = 4;
    localparam int MAXW    = 16;
    localparam int TMO     = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   len = '0;
    logic          s_valid = 1'b0;
    logic [W-1:0]  s_data = '0;
    logic          s_ready;
    logic [W-1:0]  core_im_addr = '0;
    logic [W-1:0]  im_addr;
    logic          im_we;
    logic [W-1:0]  im_wdata;
    logic          core_rst;
    logic          core_done = 1'b0;
    logic          busy;
    logic          finished;
    logic          error;
    logic [W-1:0]  cycle_count;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    program_loader #(.WIDTH(W), .ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .core_im_addr(core_im_addr), .im_addr(im_addr), .im_we(im_we),
        .im_wdata(im_wdata), .core_rst(core_rst), .core_done(core_done),
        .busy(busy), .finished(finished), .error(error),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Monitor: every BRAM write must match the next expected write in order.
    always @(negedge clk) begin
        if (im_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_we actual addr=%0h data=%0h required none at %0t",
                         im_addr, im_wdata, $time);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", im_addr, e.a);
                chk("wr_data", im_wdata, e.d);
            end
        end
    end

    // Start a load of n words and offer the first nw of them with random gaps.
    task automatic do_load(input int n, input int maxgap, input int nw);
        logic [31:0] d;
        @(posedge clk); #1;
        start = 1'b1;
        len   = (AW + 1)'(n);
        @(posedge clk); #1;
        start = 1'b0;
        chk("load_ready", {31'd0, s_ready}, 32'd1);
        chk("load_err_clr", {31'd0, error}, 32'd0);
        chk("load_cnt_clr", cycle_count, 32'd0);
        for (int i = 0; i < nw; i++) begin
            int gap;
            gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            s_valid = 1'b0;
            repeat (gap) begin
                @(posedge clk); #1;
            end
            d       = $urandom;
            s_valid = 1'b1;
            s_data  = d;
            exp_q.push_back('{32'(i * 4), d});
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        if (nw == n) begin
            chk("flush_core_rst", {31'd0, core_rst}, 32'd1);
            chk("flush_ready", {31'd0, s_ready}, 32'd0);
            chk("flush_busy", {31'd0, busy}, 32'd1);
            @(posedge clk); #1;
            chk("run_core_rst", {31'd0, core_rst}, 32'd0);
        end
    endtask

    // Run the core; done rises in run cycle k (k > TMO means never).
    task automatic run_core(input int k, input int start_at);
        int exp_cnt;
        int exp_err;
        for (int c = 1; c <= 40; c++) begin
            core_im_addr = $urandom;
            core_done    = (c == k);
            if (c == start_at) begin
                start = 1'b1;
                len   = (AW + 1)'(2);
            end
            #1;
            chk("im_addr_pass", im_addr, core_im_addr);
            chk("run_count", cycle_count, 32'(c - 1));
            @(posedge clk); #1;
            start     = 1'b0;
            core_done = 1'b0;
            if (finished) break;
        end
        exp_cnt = (k <= TMO) ? k : TMO;
        exp_err = (k <= TMO) ? 0 : 1;
        chk("halt_finished", {31'd0, finished}, 32'd1);
        chk("halt_core_rst", {31'd0, core_rst}, 32'd1);
        chk("halt_busy", {31'd0, busy}, 32'd0);
        chk("halt_count", cycle_count, 32'(exp_cnt));
        chk("halt_error", {31'd0, error}, 32'(exp_err));
    endtask

    initial begin
        #1;
        chk("rst_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_we", {31'd0, im_we}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_finished", {31'd0, finished}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        chk("rst_wdata", im_wdata, 32'd0);
        chk("rst_addr", im_addr, 32'd0);
        chk("rst_count", cycle_count, 32'd0);
        chk("rst_core_rst", {31'd0, core_rst}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;

        // Basic load, back-to-back words, done on the 10th run cycle.
        do_load(4, 0, 4);
        run_core(10, 0);

        // Backpressured load with 2-cycle gaps, then a timeout run.
        do_load(3, 0, 0);
        for (int i = 0; i < 3; i++) begin
            logic [31:0] d;
            s_valid = 1'b0;
            repeat (2) begin
                @(posedge clk); #1;
            end
            d       = $urandom;
            s_valid = 1'b1;
            s_data  = d;
            exp_q.push_back('{32'(i * 4), d});
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        chk("bp_flush_core_rst", {31'd0, core_rst}, 32'd1);
        @(posedge clk); #1;
        chk("bp_run_core_rst", {31'd0, core_rst}, 32'd0);
        run_core(TMO + 5, 0);

        // Random images and completion times; some runs see a stray start.
        for (int it = 0; it < 8; it++) begin
            int n;
            int k;
            n = int'($urandom_range(MAXW, 1));
            k = int'($urandom_range(TMO + 4, 1));
            do_load(n, 2, n);
            run_core(k, (k > 4) ? 3 : 0);
        end
        do_load(MAXW, 0, MAXW);
        run_core(1, 0);

        // Bad lengths, with the stream driven while it must be ignored.
        s_valid = 1'b1;
        s_data  = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        start = 1'b1;
        len   = '0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("len0_finished", {31'd0, finished}, 32'd1);
        chk("len0_error", {31'd0, error}, 32'd1);
        chk("len0_ready", {31'd0, s_ready}, 32'd0);
        @(posedge clk); #1;
        start = 1'b1;
        len   = (AW + 1)'(MAXW + 1);
        @(posedge clk); #1;
        start = 1'b0;
        chk("lenbig_finished", {31'd0, finished}, 32'd1);
        chk("lenbig_error", {31'd0, error}, 32'd1);
        chk("lenbig_ready", {31'd0, s_ready}, 32'd0);
        @(posedge clk); #1;
        s_valid = 1'b0;
        do_load(1, 0, 1);
        run_core(3, 0);

        // Reset after 2 of 5 words.
        do_load(5, 0, 2);
        rst = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_core_rst", {31'd0, core_rst}, 32'd1);
        chk("mid_rst_we", {31'd0, im_we}, 32'd0);
        chk("mid_rst_count", cycle_count, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        s_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_ready", {31'd0, s_ready}, 32'd0);
        s_valid = 1'b0;
        do_load(2, 1, 2);
        run_core(5, 0);

        repeat (2) @(posedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
